// File: rtl/fb_pkg.sv
// Shared constants and types for the frame-buffer arbiter (fb_arbiter, fb_wr_fifo).
package fb_pkg;
    localparam int FB_DEPTH = 24000;
    localparam int FB_AW    = 16;
    localparam int FB_DW    = 16;
    localparam int FB_SCW   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } fb_state_e;
endpackage

// File: rtl/fb_wr_fifo.sv
// Four-entry write posting FIFO (address + data) with synchronous active-low reset.
// Only instantiated when the arbiter is built with FB_WR_POST_EN.
module fb_wr_fifo
    import fb_pkg::*;
#(
    parameter int AW = FB_AW,
    parameter int DW = FB_DW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [AW-1:0] head_addr,
    output logic [DW-1:0] head_data
);
    logic [AW+DW-1:0] ent_q [4];
    logic [AW+DW-1:0] ent_d [4];
    logic [1:0]       wr_ptr_q, wr_ptr_d;
    logic [1:0]       rd_ptr_q, rd_ptr_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             do_push_s, do_pop_s;

    assign full      = (cnt_q == 3'd4);
    assign empty     = (cnt_q == 3'd0);
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign head_addr = ent_q[rd_ptr_q][AW+DW-1:DW];
    assign head_data = ent_q[rd_ptr_q][DW-1:0];

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        ent_d    = ent_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push_s) begin
            ent_d[wr_ptr_q] = {push_addr, push_data};
            wr_ptr_d        = wr_ptr_q + 2'd1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        cnt_d = cnt_q + {2'b00, do_push_s} - {2'b00, do_pop_s};
    end

    // FIFO registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                ent_q[i] <= '0;
            end
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            cnt_q    <= 3'd0;
        end else begin
            ent_q    <= ent_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: rtl/fb_arbiter.sv
// Frame-buffer arbiter: scanout reads have priority, a pending write is forced in after
// STARVE_LIMIT consecutive reads. Build option FB_WR_POST_EN adds a write posting FIFO.
module fb_arbiter
    import fb_pkg::*;
#(
    parameter int DEPTH        = FB_DEPTH,
    parameter int STARVE_LIMIT = 8,
    parameter int AW           = FB_AW,
    parameter int DW           = FB_DW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_ack,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ack,
    output logic          oob_err,
`ifdef FB_WR_POST_EN
    output logic          wr_fifo_full,
`endif
    output logic          mem_load,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_in,
    input  logic [DW-1:0] mem_out
);
    localparam logic [AW-1:0]     DEPTH_W = AW'(DEPTH);
    localparam logic [FB_SCW-1:0] LIMIT_W = FB_SCW'(STARVE_LIMIT);

    fb_state_e         state_q, state_d;
    logic [FB_SCW-1:0] starve_q, starve_d;
    logic              oob_q, oob_d;
    logic              rd_oob_q, rd_oob_d;
    logic [DW-1:0]     rd_hold_q, rd_hold_d;

    logic              wr_pend_s;
    logic [AW-1:0]     wr_head_addr_s;
    logic [DW-1:0]     wr_head_data_s;
    logic              wr_head_ok_s;
    logic              wr_oob_push_s;

`ifdef FB_WR_POST_EN
    logic fifo_full_s, fifo_empty_s, fifo_push_s, fifo_ack_s;

    // Acceptance depends only on FIFO space; out-of-range writes are acked but never stored.
    assign fifo_ack_s    = reset_n && wr_req && !fifo_full_s;
    assign fifo_push_s   = fifo_ack_s && (wr_addr < DEPTH_W);
    assign wr_oob_push_s = fifo_ack_s && !(wr_addr < DEPTH_W);
    assign wr_pend_s     = !fifo_empty_s;
    assign wr_head_ok_s  = 1'b1;
    assign wr_ack        = fifo_ack_s;
    assign wr_fifo_full  = fifo_full_s;

    fb_wr_fifo #(.AW(AW), .DW(DW)) u_wr_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push_s),
        .push_addr (wr_addr),
        .push_data (wr_data),
        .pop       (state_d == WR),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .head_addr (wr_head_addr_s),
        .head_data (wr_head_data_s)
    );
`else
    assign wr_pend_s      = wr_req;
    assign wr_head_addr_s = wr_addr;
    assign wr_head_data_s = wr_data;
    assign wr_head_ok_s   = (wr_addr < DEPTH_W);
    assign wr_oob_push_s  = 1'b0;
    assign wr_ack         = (state_d == WR);
`endif

    assign rd_valid = (state_q == RD);
    assign rd_data  = rd_valid ? (rd_oob_q ? {DW{1'b0}} : mem_out) : rd_hold_q;
    assign oob_err  = oob_q;

    // Grant decision, starvation counter and RAM-side drive.
    always_comb begin
        state_d     = IDLE;
        starve_d    = {FB_SCW{1'b0}};
        rd_ack      = 1'b0;
        mem_load    = 1'b0;
        mem_address = {AW{1'b0}};
        mem_in      = {DW{1'b0}};
        if (!reset_n) begin
            state_d = IDLE;
        end else if (rd_req && wr_pend_s) begin
            if (starve_q < LIMIT_W) begin
                state_d  = RD;
                starve_d = starve_q + FB_SCW'(1);
            end else begin
                state_d = WR;
            end
        end else if (rd_req) begin
            state_d = RD;
        end else if (wr_pend_s) begin
            state_d = WR;
        end else begin
            state_d = IDLE;
        end

        case (state_d)
            RD: begin
                rd_ack      = 1'b1;
                mem_address = rd_addr;
            end
            WR: begin
                mem_load    = wr_head_ok_s;
                mem_address = wr_head_addr_s;
                mem_in      = wr_head_data_s;
            end
            default: begin
                rd_ack = 1'b0;
            end
        endcase

        rd_oob_d  = (state_d == RD) && !(rd_addr < DEPTH_W);
        oob_d     = oob_q || rd_oob_d || wr_oob_push_s || ((state_d == WR) && !wr_head_ok_s);
        rd_hold_d = rd_valid ? rd_data : rd_hold_q;
    end

    // Arbiter state registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            starve_q  <= {FB_SCW{1'b0}};
            oob_q     <= 1'b0;
            rd_oob_q  <= 1'b0;
            rd_hold_q <= {DW{1'b0}};
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            oob_q     <= oob_d;
            rd_oob_q  <= rd_oob_d;
            rd_hold_q <= rd_hold_d;
        end
    end
endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter (default build): directed steps plus random traffic checked against
// a rule-level model of grants, starvation, RAM contents and sticky error.
`timescale 1ns/1ps
module tb_fb_arbiter;
    localparam int DEPTH = 24000;
    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        reset_n, rd_req, wr_req;
    logic [15:0] rd_addr, wr_addr, wr_data;
    logic        rd_ack, rd_valid, wr_ack, oob_err, mem_load;
    logic [15:0] rd_data, mem_address, mem_in, mem_out;
`ifdef FB_WR_POST_EN
    logic        wr_fifo_full;
`endif

    always #5 clk = ~clk;

    fb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT), .AW(16), .DW(16)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_ack      (rd_ack),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ack      (wr_ack),
        .oob_err     (oob_err),
`ifdef FB_WR_POST_EN
        .wr_fifo_full(wr_fifo_full),
`endif
        .mem_load    (mem_load),
        .mem_address (mem_address),
        .mem_in      (mem_in),
        .mem_out     (mem_out)
    );

    // Single-port RAM: registered read, read suppressed on write cycles.
    logic [15:0] ram [0:DEPTH-1];
    always @(posedge clk) begin
        if (mem_load) begin
            if (int'(mem_address) < DEPTH) ram[mem_address] <= mem_in;
        end else if (int'(mem_address) < DEPTH) begin
            mem_out <= ram[mem_address];
        end else begin
            mem_out <= 16'hDEAD;
        end
    end

    int          n_vec = 0;
    int          n_err = 0;
    int          starve;
    bit          e_valid, e_oob;
    logic [15:0] e_pend, e_hold;
    logic [15:0] shadow [0:127];
    logic        obs_wr_ack, obs_rd_valid, obs_mem_load;
    logic [15:0] obs_rd_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check this cycle's outputs at negedge, then advance the model past posedge.
    task automatic step();
        bit g_rd, g_wr, wr_ok, rd_ok;
        @(negedge clk);
        g_rd = 1'b0;
        g_wr = 1'b0;
        if (reset_n) begin
            if (rd_req && wr_req) begin
                if (starve < LIMIT) g_rd = 1'b1;
                else g_wr = 1'b1;
            end else begin
                g_rd = rd_req;
                g_wr = wr_req;
            end
        end
        wr_ok = int'(wr_addr) < DEPTH;
        rd_ok = int'(rd_addr) < DEPTH;
        chk("rd_ack", {31'd0, rd_ack}, {31'd0, g_rd});
        chk("wr_ack", {31'd0, wr_ack}, {31'd0, g_wr});
        chk("mem_load", {31'd0, mem_load}, {31'd0, g_wr && wr_ok});
        chk("mem_address", {16'd0, mem_address}, {16'd0, g_rd ? rd_addr : (g_wr ? wr_addr : 16'd0)});
        chk("mem_in", {16'd0, mem_in}, {16'd0, g_wr ? wr_data : 16'd0});
        chk("rd_valid", {31'd0, rd_valid}, {31'd0, e_valid});
        chk("rd_data", {16'd0, rd_data}, {16'd0, e_valid ? e_pend : e_hold});
        chk("oob_err", {31'd0, oob_err}, {31'd0, e_oob});
        obs_wr_ack   = wr_ack;
        obs_mem_load = mem_load;
        obs_rd_valid = rd_valid;
        obs_rd_data  = rd_data;
        @(posedge clk);
        if (!reset_n) begin
            starve  = 0;
            e_valid = 1'b0;
            e_hold  = 16'd0;
            e_oob   = 1'b0;
        end else begin
            if (e_valid) e_hold = e_pend;
            if (g_rd && wr_req) starve++;
            else starve = 0;
            if (g_wr) begin
                if (wr_ok) shadow[wr_addr[6:0]] = wr_data;
                else e_oob = 1'b1;
            end
            e_valid = g_rd;
            if (g_rd) begin
                if (rd_ok) begin
                    e_pend = shadow[rd_addr[6:0]];
                end else begin
                    e_pend = 16'd0;
                    e_oob  = 1'b1;
                end
            end
        end
        #1;
    endtask

    function automatic logic [15:0] rand_addr();
        if ($urandom_range(0, 15) == 0) return 16'(DEPTH + $urandom_range(0, 100));
        return 16'($urandom_range(0, 31));
    endfunction

    initial begin
        int wr_cnt, first_wr;
        reset_n = 1'b0;
        rd_req  = 1'b0;
        wr_req  = 1'b0;
        rd_addr = 16'd0;
        wr_addr = 16'd0;
        wr_data = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        starve  = 0;
        e_valid = 1'b0;
        e_oob   = 1'b0;
        e_pend  = 16'd0;
        e_hold  = 16'd0;
        step();
        reset_n = 1'b1;

        // Fill addresses 0..31 through the writer; word 5 gets A5A5.
        for (int i = 0; i < 32; i++) begin
            wr_req  = 1'b1;
            wr_addr = 16'(i);
            wr_data = (i == 5) ? 16'hA5A5 : 16'($urandom);
            step();
        end
        wr_req = 1'b0;

        rd_req  = 1'b1;
        rd_addr = 16'd5;
        step();
        rd_req = 1'b0;
        step();
        chk("tp_read5_valid", {31'd0, obs_rd_valid}, 32'd1);
        chk("tp_read5_data", {16'd0, obs_rd_data}, 32'h0000A5A5);

        wr_req  = 1'b1;
        wr_addr = 16'd100;
        wr_data = 16'h1234;
        step();
        chk("tp_wr100_ack", {31'd0, obs_wr_ack}, 32'd1);
        chk("tp_wr100_load", {31'd0, obs_mem_load}, 32'd1);
        wr_req  = 1'b0;
        rd_req  = 1'b1;
        rd_addr = 16'd100;
        step();
        rd_req = 1'b0;
        step();
        chk("tp_rd100_data", {16'd0, obs_rd_data}, 32'h00001234);

        // Sustained contention: writes every ninth cycle, first after eight reads.
        step();
        wr_cnt   = 0;
        first_wr = -1;
        for (int k = 0; k < 27; k++) begin
            rd_req  = 1'b1;
            wr_req  = 1'b1;
            rd_addr = 16'($urandom_range(0, 31));
            wr_addr = 16'($urandom_range(0, 31));
            wr_data = 16'($urandom);
            step();
            if (obs_wr_ack) begin
                wr_cnt++;
                if (first_wr < 0) first_wr = k;
            end
        end
        chk("starve_wr_count", 32'(wr_cnt), 32'd3);
        chk("starve_first_wr", 32'(first_wr), 32'd8);
        rd_req = 1'b0;
        wr_req = 1'b0;
        step();

        // Out-of-range write then read.
        wr_req  = 1'b1;
        wr_addr = 16'd24000;
        wr_data = 16'hBEEF;
        step();
        chk("oob_wr_ack", {31'd0, obs_wr_ack}, 32'd1);
        chk("oob_wr_load", {31'd0, obs_mem_load}, 32'd0);
        wr_req  = 1'b0;
        rd_req  = 1'b1;
        rd_addr = 16'd24001;
        step();
        rd_req = 1'b0;
        step();
        chk("oob_rd_valid", {31'd0, obs_rd_valid}, 32'd1);
        chk("oob_rd_data", {16'd0, obs_rd_data}, 32'd0);

        // Random traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            reset_n = ($urandom_range(0, 63) != 0);
            rd_req  = 1'($urandom_range(0, 1));
            wr_req  = 1'($urandom_range(0, 1));
            rd_addr = rand_addr();
            wr_addr = rand_addr();
            wr_data = 16'($urandom);
            step();
        end

        // Reset on the cycle after a read grant cancels the pending data.
        reset_n = 1'b1;
        rd_req  = 1'b0;
        wr_req  = 1'b0;
        step();
        rd_req  = 1'b1;
        rd_addr = 16'd3;
        step();
        rd_req  = 1'b0;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        chk("rst_mid_read_valid", {31'd0, obs_rd_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
